// File: rtl/invader_hit_detect_pkg.sv
// ---------------------------------------------------------------------------
// invaders_pkg
// Shared definitions for the invader fleet blocks: default grid geometry,
// per-row point weights, common field widths and the hit-detect FSM states.
// No ports (package only).
// ---------------------------------------------------------------------------
package invaders_pkg;

    // Default fleet geometry in pixels / cells.
    localparam int ROWS   = 5;
    localparam int COLS   = 11;
    localparam int INV_W  = 32;
    localparam int INV_H  = 24;
    localparam int STEP_X = 48;
    localparam int STEP_Y = 32;

    // Field widths shared between the interface and the datapath.
    localparam int POS_W   = 10;
    localparam int DELTA_W = 11;
    localparam int ROW_W   = 3;
    localparam int COL_W   = 4;
    localparam int KILL_W  = 7;
    localparam int SCORE_W = 16;

    // Points awarded per destroyed invader, by row.
    localparam logic [SCORE_W-1:0] ROW0_POINTS      = 16'd30;
    localparam logic [SCORE_W-1:0] ROW12_POINTS     = 16'd20;
    localparam logic [SCORE_W-1:0] ROW_OTHER_POINTS = 16'd10;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SCAN_COL,
        SCAN_ROW,
        CHECK,
        WAIT_RELEASE
    } hit_state_t;

    // Row 0 is the top row and is worth the most.
    function automatic logic [SCORE_W-1:0] row_points(input logic [ROW_W-1:0] row);
        case (row)
            3'd0:       row_points = ROW0_POINTS;
            3'd1, 3'd2: row_points = ROW12_POINTS;
            default:    row_points = ROW_OTHER_POINTS;
        endcase
    endfunction

endpackage

// File: rtl/invader_hit_detect_if.sv
// ---------------------------------------------------------------------------
// invader_hit_detect_if
// Bundles the fleet position, bullet position and the hit/alive results
// exchanged between the game logic and invader_hit_detect.
//   master : game side (drives game_start, fleet and bullet positions,
//            reads alive_mask, hit, hit_row, hit_col, bullet_clear,
//            kill_count, all_dead, score)
//   slave  : invader_hit_detect (the reverse directions)
// ---------------------------------------------------------------------------
interface invader_hit_detect_if #(
    parameter int ROWS = invaders_pkg::ROWS,
    parameter int COLS = invaders_pkg::COLS
);
    import invaders_pkg::*;

    logic                   game_start;
    logic [POS_W-1:0]       fleet_xpos;
    logic [POS_W-1:0]       fleet_ypos;
    logic [POS_W-1:0]       bullet_xpos;
    logic [POS_W-1:0]       bullet_ypos;
    logic                   bullet_valid;

    logic [ROWS*COLS-1:0]   alive_mask;
    logic                   hit;
    logic [ROW_W-1:0]       hit_row;
    logic [COL_W-1:0]       hit_col;
    logic                   bullet_clear;
    logic [KILL_W-1:0]      kill_count;
    logic                   all_dead;
    logic [SCORE_W-1:0]     score;

    modport master (
        output game_start, fleet_xpos, fleet_ypos,
               bullet_xpos, bullet_ypos, bullet_valid,
        input  alive_mask, hit, hit_row, hit_col,
               bullet_clear, kill_count, all_dead, score
    );

    modport slave (
        input  game_start, fleet_xpos, fleet_ypos,
               bullet_xpos, bullet_ypos, bullet_valid,
        output alive_mask, hit, hit_row, hit_col,
               bullet_clear, kill_count, all_dead, score
    );

endinterface

// File: rtl/invader_hit_detect_scan.sv
// ---------------------------------------------------------------------------
// grid_index_scan
// Iterative subtract-and-count for one axis of the invader grid. After a
// load, every enabled cycle removes one STEP from the residue and bumps the
// cell count, until the residue is below STEP or the count reaches LIMIT.
// The residue then holds the offset inside the resolved cell.
//   clk65MHz, rst : clock and synchronous active-high reset
//   load          : capture load_value, clear count
//   load_value    : non-negative offset from the fleet origin
//   step_en       : perform one step when can_step is high
//   residue       : remaining offset
//   count         : resolved cell index along this axis
//   can_step      : another step is still possible
// ---------------------------------------------------------------------------
module grid_index_scan
    import invaders_pkg::*;
#(
    parameter int STEP  = STEP_X,
    parameter int LIMIT = COLS - 1,
    parameter int VAL_W = POS_W,
    parameter int CNT_W = COL_W
) (
    input  logic             clk65MHz,
    input  logic             rst,
    input  logic             load,
    input  logic [VAL_W-1:0] load_value,
    input  logic             step_en,
    output logic [VAL_W-1:0] residue,
    output logic [CNT_W-1:0] count,
    output logic             can_step
);

    // The count cap keeps a bullet past the last cell from wrapping into a
    // nonexistent column/row; the oversized residue then fails the sprite test.
    assign can_step = (residue >= VAL_W'(STEP)) && (count < CNT_W'(LIMIT));

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            residue <= '0;
            count   <= '0;
        end else if (load) begin
            residue <= load_value;
            count   <= '0;
        end else if (step_en && can_step) begin
            residue <= residue - VAL_W'(STEP);
            count   <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/invader_hit_detect.sv
// ---------------------------------------------------------------------------
// invader_hit_detect
// Resolves which invader cell, if any, the player bullet overlaps and keeps
// the fleet alive bitmap, kill count and score.
//   clk65MHz : system clock
//   rst      : synchronous active-high reset
//   bus      : invader_hit_detect_if.slave (game_start, fleet/bullet
//              positions in; alive_mask, hit, hit_row, hit_col,
//              bullet_clear, kill_count, all_dead, score out)
// Optional feature: define INVADER_HIT_SCORE_EN to accumulate row points in
// score (saturating). Without it score is constant zero.
// ---------------------------------------------------------------------------
module invader_hit_detect
    import invaders_pkg::*;
#(
    parameter int ROWS   = invaders_pkg::ROWS,
    parameter int COLS   = invaders_pkg::COLS,
    parameter int INV_W  = invaders_pkg::INV_W,
    parameter int INV_H  = invaders_pkg::INV_H,
    parameter int STEP_X = invaders_pkg::STEP_X,
    parameter int STEP_Y = invaders_pkg::STEP_Y
) (
    input  logic                 clk65MHz,
    input  logic                 rst,
    invader_hit_detect_if.slave  bus
);

    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);

    hit_state_t state, next_state;

    logic signed [DELTA_W-1:0] dx_raw, dy_raw;
    logic                      load_scan, step_x, step_y, do_hit, fleet_load;

    logic [POS_W-1:0] x_residue, y_residue;
    logic [COL_W-1:0] x_count;
    logic [ROW_W-1:0] y_count;
    logic             x_can_step, y_can_step;

    logic [IDX_W-1:0] cell_idx;
    logic             cell_alive, in_sprite;

    logic [CELLS-1:0]  alive_mask_q;
    logic              hit_q, bullet_clear_q, all_dead_q;
    logic [ROW_W-1:0]  hit_row_q;
    logic [COL_W-1:0]  hit_col_q;
    logic [KILL_W-1:0] kill_count_q;

    // Offsets are formed one bit wider so a bullet left of or above the fleet
    // shows up as a negative value instead of wrapping.
    assign dx_raw = $signed({1'b0, bus.bullet_xpos}) - $signed({1'b0, bus.fleet_xpos});
    assign dy_raw = $signed({1'b0, bus.bullet_ypos}) - $signed({1'b0, bus.fleet_ypos});

    grid_index_scan #(
        .STEP  (STEP_X),
        .LIMIT (COLS - 1),
        .VAL_W (POS_W),
        .CNT_W (COL_W)
    ) u_scan_x (
        .clk65MHz   (clk65MHz),
        .rst        (rst),
        .load       (load_scan),
        .load_value (dx_raw[POS_W-1:0]),
        .step_en    (step_x),
        .residue    (x_residue),
        .count      (x_count),
        .can_step   (x_can_step)
    );

    grid_index_scan #(
        .STEP  (STEP_Y),
        .LIMIT (ROWS - 1),
        .VAL_W (POS_W),
        .CNT_W (ROW_W)
    ) u_scan_y (
        .clk65MHz   (clk65MHz),
        .rst        (rst),
        .load       (load_scan),
        .load_value (dy_raw[POS_W-1:0]),
        .step_en    (step_y),
        .residue    (y_residue),
        .count      (y_count),
        .can_step   (y_can_step)
    );

    assign cell_idx   = IDX_W'(int'(y_count) * COLS + int'(x_count));
    assign cell_alive = alive_mask_q[cell_idx];
    assign in_sprite  = (x_residue < POS_W'(INV_W)) && (y_residue < POS_W'(INV_H));

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle control strobes for the datapath.
    always_comb begin
        next_state = state;
        load_scan  = 1'b0;
        step_x     = 1'b0;
        step_y     = 1'b0;
        do_hit     = 1'b0;
        fleet_load = 1'b0;

        case (state)
            IDLE: begin
                if (bus.game_start) begin
                    fleet_load = 1'b1;
                    next_state = ARMED;
                end
            end
            ARMED: begin
                if (bus.bullet_valid && !all_dead_q) begin
                    if (dx_raw < 0 || dy_raw < 0) begin
                        next_state = WAIT_RELEASE;
                    end else begin
                        load_scan  = 1'b1;
                        next_state = SCAN_COL;
                    end
                end
            end
            SCAN_COL: begin
                if (x_can_step) begin
                    step_x = 1'b1;
                end else begin
                    next_state = SCAN_ROW;
                end
            end
            SCAN_ROW: begin
                if (y_can_step) begin
                    step_y = 1'b1;
                end else begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                do_hit     = in_sprite && cell_alive;
                next_state = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!bus.bullet_valid) begin
                    next_state = ARMED;
                end
            end
            default: next_state = IDLE;
        endcase

        // A restart outranks whatever the current bullet was doing.
        if (state != IDLE && bus.game_start) begin
            fleet_load = 1'b1;
            load_scan  = 1'b0;
            do_hit     = 1'b0;
            next_state = ARMED;
        end
    end

    // Fleet bitmap, hit strobes and kill counter. all_dead trails kill_count
    // by one cycle because it is derived from the registered count.
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            alive_mask_q   <= '0;
            hit_q          <= 1'b0;
            bullet_clear_q <= 1'b0;
            hit_row_q      <= '0;
            hit_col_q      <= '0;
            kill_count_q   <= '0;
            all_dead_q     <= 1'b0;
        end else begin
            hit_q          <= 1'b0;
            bullet_clear_q <= 1'b0;
            all_dead_q     <= (kill_count_q == KILL_W'(CELLS));
            if (fleet_load) begin
                alive_mask_q <= '1;
                kill_count_q <= '0;
            end else if (do_hit) begin
                alive_mask_q[cell_idx] <= 1'b0;
                hit_q                  <= 1'b1;
                bullet_clear_q         <= 1'b1;
                hit_row_q              <= y_count;
                hit_col_q              <= x_count;
                kill_count_q           <= kill_count_q + KILL_W'(1);
            end
        end
    end

`ifdef INVADER_HIT_SCORE_EN
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W:0]   score_sum;

    assign score_sum = {1'b0, score_q} + {1'b0, row_points(y_count)};

    // Saturating points accumulator, cleared with the fleet reload.
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            score_q <= '0;
        end else if (fleet_load) begin
            score_q <= '0;
        end else if (do_hit) begin
            score_q <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end
    end

    assign bus.score = score_q;
`else
    assign bus.score = '0;
`endif

    assign bus.alive_mask   = alive_mask_q;
    assign bus.hit          = hit_q;
    assign bus.bullet_clear = bullet_clear_q;
    assign bus.hit_row      = hit_row_q;
    assign bus.hit_col      = hit_col_q;
    assign bus.kill_count   = kill_count_q;
    assign bus.all_dead     = all_dead_q;

endmodule

// File: tb/tb_invader_hit_detect.sv
// ---------------------------------------------------------------------------
// tb_invader_hit_detect
// Directed bench for invader_hit_detect: a table of bullet/fleet positions
// with hand-computed cell, latency and hit expectations, plus sequences for
// held bullets, restart priority, clearing the whole fleet and reset during
// a scan. Score expectations follow INVADER_HIT_SCORE_EN.
// ---------------------------------------------------------------------------
module tb_invader_hit_detect;

    localparam int N_ROWS    = 5;
    localparam int N_COLS    = 11;
    localparam int N_CELLS   = N_ROWS * N_COLS;
    localparam int LAT_LIMIT = 30;

    typedef struct {
        int fx;
        int fy;
        int bx;
        int by;
        int exp_hit;
        int exp_row;
        int exp_col;
    } vec_t;

    logic clk65MHz;
    logic rst;

    invader_hit_detect_if bus ();

    invader_hit_detect dut (
        .clk65MHz (clk65MHz),
        .rst      (rst),
        .bus      (bus)
    );

    initial clk65MHz = 1'b0;
    always #8 clk65MHz = ~clk65MHz;

    int errors = 0;
    int checks = 0;

    logic [N_CELLS-1:0] model_mask;
    int                 model_kills;
    int                 model_score;
    int                 last_row;
    int                 last_col;

    vec_t vecs [11];

    function automatic int rowPoints(input int r);
        if (r == 0)      return 30;
        else if (r <= 2) return 20;
        else             return 10;
    endfunction

    function automatic logic [63:0] expScore();
`ifdef INVADER_HIT_SCORE_EN
        return 64'(model_score);
`else
        return 64'd0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectKill(input int r, input int c);
        model_mask[r*N_COLS+c] = 1'b0;
        model_kills++;
        model_score += rowPoints(r);
        last_row = r;
        last_col = c;
    endtask

    task automatic reloadModel();
        model_mask  = '1;
        model_kills = 0;
        model_score = 0;
    endtask

    // Fires one bullet starting just after a clock edge. Latency is the
    // number of edges from driving bullet_valid until hit is seen.
    task automatic applyStimulus(
        input  logic [9:0] fx, input logic [9:0] fy,
        input  logic [9:0] bx, input logic [9:0] by,
        input  logic keep_valid, input logic move_fleet, input logic [9:0] late_fx,
        output logic got_hit, output int lat, output logic clr_seen,
        output logic single_pulse, output logic ad_hit, output logic ad_next
    );
        bus.fleet_xpos   = fx;
        bus.fleet_ypos   = fy;
        bus.bullet_xpos  = bx;
        bus.bullet_ypos  = by;
        bus.bullet_valid = 1'b1;
        got_hit      = 1'b0;
        lat          = 0;
        clr_seen     = 1'b0;
        single_pulse = 1'b0;
        ad_hit       = 1'b0;
        ad_next      = 1'b0;
        for (int n = 1; n <= LAT_LIMIT; n++) begin
            @(posedge clk65MHz);
            #1;
            if (move_fleet && n == 1) bus.fleet_xpos = late_fx;
            if (bus.hit) begin
                got_hit  = 1'b1;
                lat      = n;
                clr_seen = bus.bullet_clear;
                ad_hit   = bus.all_dead;
                break;
            end
        end
        if (got_hit) begin
            @(posedge clk65MHz);
            #1;
            single_pulse = !bus.hit && !bus.bullet_clear;
            ad_next      = bus.all_dead;
        end
        if (!keep_valid) begin
            bus.bullet_valid = 1'b0;
            repeat (2) @(posedge clk65MHz);
            #1;
        end
    endtask

    task automatic pulseGameStart();
        bus.game_start = 1'b1;
        @(posedge clk65MHz);
        #1;
        bus.game_start = 1'b0;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, " alive_mask"}, 64'(bus.alive_mask), 64'(model_mask));
        checkOutput({tag, " kill_count"}, 64'(bus.kill_count), 64'(model_kills));
        checkOutput({tag, " score"},      64'(bus.score),      expScore());
        checkOutput({tag, " hit_row"},    64'(bus.hit_row),    64'(last_row));
        checkOutput({tag, " hit_col"},    64'(bus.hit_col),    64'(last_col));
    endtask

    initial begin
        logic got_hit, clr_seen, single_pulse, ad_hit, ad_next;
        int   lat;
        int   hits_seen;

        // Hand-computed vectors. Fleet origin (100,50) unless noted.
        vecs[0]  = '{100, 50, 201,  92, 1, 1,  2};  // dx=101 dy=42 -> cell 13
        vecs[1]  = '{100, 50, 140,  60, 0, 0,  0};  // dx=40 lands in the gap
        vecs[2]  = '{100, 50, 201,  92, 0, 0,  0};  // same cell, now dead
        vecs[3]  = '{100, 50, 100,  50, 1, 0,  0};  // fleet origin itself
        vecs[4]  = '{100, 50,  99,  60, 0, 0,  0};  // dx=-1
        vecs[5]  = '{100, 50, 611, 201, 1, 4, 10};  // far corner, worst latency
        vecs[6]  = '{100, 50, 628,  50, 0, 0,  0};  // dx=528 beyond last column
        vecs[7]  = '{100, 50, 100, 210, 0, 0,  0};  // dy=160 beyond last row
        vecs[8]  = '{100, 50, 275, 137, 1, 2,  3};  // dx=175 dy=87 edge pixels
        vecs[9]  = '{100, 50, 100,  74, 0, 0,  0};  // dy=24 in the row gap
        vecs[10] = '{  0,  0,  48,  32, 1, 1,  1};  // other fleet position

        rst              = 1'b1;
        bus.game_start   = 1'b0;
        bus.fleet_xpos   = '0;
        bus.fleet_ypos   = '0;
        bus.bullet_xpos  = '0;
        bus.bullet_ypos  = '0;
        bus.bullet_valid = 1'b0;
        model_mask  = '0;
        model_kills = 0;
        model_score = 0;
        last_row    = 0;
        last_col    = 0;

        repeat (3) @(posedge clk65MHz);
        #1;
        rst = 1'b0;
        @(posedge clk65MHz);
        #1;
        checkState("reset");
        checkOutput("reset hit",          64'(bus.hit),          64'd0);
        checkOutput("reset bullet_clear", 64'(bus.bullet_clear), 64'd0);
        checkOutput("reset all_dead",     64'(bus.all_dead),     64'd0);

        pulseGameStart();
        reloadModel();
        checkState("start");
        @(posedge clk65MHz);
        #1;
        checkOutput("start all_dead", 64'(bus.all_dead), 64'd0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(10'(vecs[i].fx), 10'(vecs[i].fy), 10'(vecs[i].bx), 10'(vecs[i].by),
                          1'b0, 1'b0, 10'd0,
                          got_hit, lat, clr_seen, single_pulse, ad_hit, ad_next);
            if (vecs[i].exp_hit != 0) expectKill(vecs[i].exp_row, vecs[i].exp_col);
            checkOutput($sformatf("vec%0d hit", i),          64'(got_hit),      64'(vecs[i].exp_hit));
            checkOutput($sformatf("vec%0d latency", i),      64'(lat),
                        (vecs[i].exp_hit != 0) ? 64'(4 + vecs[i].exp_row + vecs[i].exp_col) : 64'd0);
            checkOutput($sformatf("vec%0d bullet_clear", i), 64'(clr_seen),     64'(vecs[i].exp_hit));
            checkOutput($sformatf("vec%0d one_cycle", i),    64'(single_pulse), 64'(vecs[i].exp_hit));
            checkState($sformatf("vec%0d", i));
        end

        // Held bullet: first hit, then moved over a live cell while held.
        applyStimulus(10'd100, 10'd50, 10'd196, 10'd50, 1'b1, 1'b0, 10'd0,
                      got_hit, lat, clr_seen, single_pulse, ad_hit, ad_next);
        expectKill(0, 2);
        checkOutput("hold first hit", 64'(got_hit), 64'd1);
        checkOutput("hold first latency", 64'(lat), 64'd6);
        bus.bullet_xpos = 10'd148;
        hits_seen = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk65MHz);
            #1;
            if (bus.hit) hits_seen++;
        end
        checkOutput("hold no rehit", 64'(hits_seen), 64'd0);
        checkState("hold");
        bus.bullet_valid = 1'b0;
        repeat (2) @(posedge clk65MHz);
        #1;

        // Re-fire after release; fleet jumps away right after sampling.
        applyStimulus(10'd100, 10'd50, 10'd148, 10'd50, 1'b0, 1'b1, 10'd300,
                      got_hit, lat, clr_seen, single_pulse, ad_hit, ad_next);
        expectKill(0, 1);
        checkOutput("refire hit", 64'(got_hit), 64'd1);
        checkOutput("refire latency", 64'(lat), 64'd5);
        checkState("refire");

        // game_start arriving in CHECK beats the pending hit on cell 13... now
        // reloaded: bullet at (201,92) reaches CHECK on edge 7.
        pulseGameStart();
        reloadModel();
        repeat (2) @(posedge clk65MHz);
        #1;
        bus.fleet_xpos   = 10'd100;
        bus.fleet_ypos   = 10'd50;
        bus.bullet_xpos  = 10'd201;
        bus.bullet_ypos  = 10'd92;
        bus.bullet_valid = 1'b1;
        repeat (6) @(posedge clk65MHz);
        #1;
        bus.game_start = 1'b1;
        @(posedge clk65MHz);
        #1;
        bus.game_start   = 1'b0;
        bus.bullet_valid = 1'b0;
        checkOutput("priority hit", 64'(bus.hit), 64'd0);
        checkState("priority");
        repeat (2) @(posedge clk65MHz);
        #1;
        checkOutput("priority no late hit", 64'(bus.kill_count), 64'd0);

        // Clear the whole fleet by shooting every cell origin.
        for (int r = 0; r < N_ROWS; r++) begin
            for (int c = 0; c < N_COLS; c++) begin
                applyStimulus(10'd100, 10'd50, 10'(100 + 48 * c), 10'(50 + 32 * r),
                              1'b0, 1'b0, 10'd0,
                              got_hit, lat, clr_seen, single_pulse, ad_hit, ad_next);
                expectKill(r, c);
                checkOutput($sformatf("kill r%0d c%0d", r, c), 64'(got_hit), 64'd1);
                checkOutput($sformatf("kill r%0d c%0d latency", r, c), 64'(lat), 64'(4 + r + c));
            end
        end
        checkOutput("all_dead with last hit", 64'(ad_hit), 64'd0);
        checkOutput("all_dead one cycle later", 64'(ad_next), 64'd1);
        checkState("all killed");
        checkOutput("all_dead held", 64'(bus.all_dead), 64'd1);

        pulseGameStart();
        reloadModel();
        checkState("restart");
        @(posedge clk65MHz);
        #1;
        checkOutput("restart all_dead", 64'(bus.all_dead), 64'd0);
        @(posedge clk65MHz);
        #1;

        // Reset while the column scan is running.
        bus.fleet_xpos   = 10'd100;
        bus.fleet_ypos   = 10'd50;
        bus.bullet_xpos  = 10'd611;
        bus.bullet_ypos  = 10'd201;
        bus.bullet_valid = 1'b1;
        repeat (2) @(posedge clk65MHz);
        #1;
        rst = 1'b1;
        @(posedge clk65MHz);
        #1;
        rst = 1'b0;
        model_mask  = '0;
        model_kills = 0;
        model_score = 0;
        last_row    = 0;
        last_col    = 0;
        checkState("midscan reset");
        checkOutput("midscan reset hit",          64'(bus.hit),          64'd0);
        checkOutput("midscan reset bullet_clear", 64'(bus.bullet_clear), 64'd0);
        checkOutput("midscan reset all_dead",     64'(bus.all_dead),     64'd0);
        hits_seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk65MHz);
            #1;
            if (bus.hit) hits_seen++;
        end
        checkOutput("idle after reset no hit", 64'(hits_seen), 64'd0);
        checkOutput("idle after reset mask", 64'(bus.alive_mask), 64'd0);
        bus.bullet_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/invader_hit_detect.md
# invader_hit_detect

Collision and alive-state tracker for the invader fleet. It consumes the fleet origin (`xpos`/`ypos`) produced by the invader movement stage and the player bullet position. It resolves which grid cell, if any, the bullet overlaps, and maintains the alive bitmap that the invader draw stage and game controller read. Cell resolution uses an iterative column/row scan, so there is no divider.

## Interface
- `ROWS`, 5, number of invader rows
- `COLS`, 11, number of invader columns
- `INV_W`, 32, invader sprite width in pixels
- `INV_H`, 24, invader sprite height in pixels
- `STEP_X`, 48, horizontal pitch between invader origins
- `STEP_Y`, 32, vertical pitch between invader origins
- `clk65MHz` in 1: system clock; the block uses one clock only
- `rst` in 1: synchronous, active-high reset
- `game_start` in 1: level pulse that reloads the fleet
- `fleet_xpos` in 10: fleet origin x, from invader_move
- `fleet_ypos` in 10: fleet origin y, from invader_move
- `bullet_xpos` in 10: bullet tip x
- `bullet_ypos` in 10: bullet tip y
- `bullet_valid` in 1: a bullet is in flight
- `alive_mask` out ROWS*COLS: bit `row*COLS+col` is set while that invader is alive
- `hit` out 1: one-cycle pulse when an invader is destroyed
- `hit_row` out 3: row of the last hit
- `hit_col` out 4: column of the last hit
- `bullet_clear` out 1: one-cycle pulse, coincident with `hit`, that tells the bullet logic to retire the bullet
- `kill_count` out 7: number of invaders destroyed since `game_start`
- `all_dead` out 1: high when `kill_count == ROWS*COLS`
- `score` out 16: accumulated points (see Configuration)

## Operation
- FSM states: IDLE, ARMED, SCAN_COL, SCAN_ROW, CHECK, WAIT_RELEASE.
- IDLE: `alive_mask` = 0. On `game_start`, the block goes to ARMED.
- Fleet load: on entry from `game_start`, `alive_mask` is set to all ones and `kill_count` and `score` are cleared.
- ARMED: when `bullet_valid` is high, the block captures `dx = bullet_xpos - fleet_xpos` and `dy = bullet_ypos - fleet_ypos`.
  - Both are computed as 11-bit signed values.
  - If either is negative, the bullet is a miss and the block goes to WAIT_RELEASE.
  - Otherwise the block clears `col` and `row` and goes to SCAN_COL.
- SCAN_COL: each cycle, if `dx >= STEP_X` and `col < COLS-1`, then `dx -= STEP_X` and `col++`. Otherwise the block goes to SCAN_ROW.
- SCAN_ROW: the same procedure using `dy`, `STEP_Y`, `row` and `ROWS-1`. When it terminates, the block goes to CHECK.
- CHECK: a hit requires all of `dx < INV_W`, `dy < INV_H` and `alive_mask[row*COLS+col]`. On a hit:
  - clear that bit;
  - pulse `hit` and `bullet_clear`;
  - latch `hit_row` and `hit_col`;
  - increment `kill_count`.
  - The block then goes to WAIT_RELEASE.
- A bullet in the gap between sprites, beyond the last column or row, or over a dead cell is a miss. A miss changes no state except the FSM.
- WAIT_RELEASE: the block waits for `bullet_valid` = 0, then returns to ARMED. This guarantees at most one kill per bullet.
- `game_start` in any non-IDLE state reloads the fleet and forces ARMED. It takes priority over a simultaneous bullet event or hit.
- `all_dead`: registered, updated one cycle after `kill_count`. In ARMED with `all_dead` = 1, bullets are ignored.
- Reset mid-scan: the FSM goes to IDLE and all outputs return to their reset values.

## Timing
- Reset values: `alive_mask`, `hit`, `hit_row`, `hit_col`, `bullet_clear`, `kill_count`, `all_dead` and `score` are all 0.
- Latency from `bullet_valid` sampled in ARMED to the `hit` pulse is `4 + col + row` cycles. The worst case is `COLS+ROWS+2`, which is 18 with the defaults.
- All outputs are registered. `hit` and `bullet_clear` are high for exactly one cycle.
- The fleet position is sampled only in ARMED. Later fleet movement does not affect a scan already in progress.

## Configuration
- `INVADER_HIT_SCORE_EN` defined: on each hit, `score` adds the row weight, saturating at 16'hFFFF.
  - Row 0 adds 30.
  - Rows 1-2 add 20.
  - All other rows add 10.
- Not defined: `score` is tied to 0 and no accumulator logic is synthesised.

## Structure
- A shared package `invaders_pkg` holds:
  - the default `ROWS`, `COLS`, `INV_W`, `INV_H`, `STEP_X` and `STEP_Y`;
  - the row point weights;
  - the FSM state enum typedef.
- One sub-module, `grid_index_scan`, implements the iterative subtract-and-count for a single axis. It is instantiated twice (x and y) and sequenced by the FSM.

## Test plan
- Reset, then `game_start` -> `alive_mask` = all 55 ones, `kill_count` = 0, `all_dead` = 0.
- Fleet (100,50), bullet (201,92) valid -> after 7 cycles: `hit` pulse, `hit_row` = 1, `hit_col` = 2, bit 13 cleared, `kill_count` = 1, `score` = 20 (macro on).
- Fleet (100,50), bullet (140,60) -> dx = 40 falls in the gap -> no `hit`, `alive_mask` unchanged. The same cell hit twice -> the second attempt is a miss.
- Hold `bullet_valid` high after a hit with the bullet moved over another live cell -> no second hit until `bullet_valid` drops.
- Destroy all 55 invaders -> `kill_count` = 55, then `all_dead` = 1 one cycle later. `game_start` -> mask reloaded, `all_dead` = 0.
- Assert `rst` during SCAN_COL -> next cycle: IDLE, all outputs 0, no `hit` pulse.
